// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main-control FSM with request/ready memory stalls.
// Optional jump support is enabled by defining MC_JUMP_EN.
module mc_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] IDLE    = 4'd15;
   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] RTYPEEX = 4'd6;
   localparam logic [3:0] RTYPEWB = 4'd7;
   localparam logic [3:0] BEQEX   = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] ADDIWB  = 4'd10;
`ifdef MC_JUMP_EN
   localparam logic [3:0] JEX     = 4'd11;
`endif

   logic [3:0] next;
   logic [3:0] jdst;
   logic       lw, sw, rtype, beq, addi, jmp, legal;

   assign lw    = opcode == 6'b100011;
   assign sw    = opcode == 6'b101011;
   assign rtype = opcode == 6'b000000;
   assign beq   = opcode == 6'b000100;
   assign addi  = opcode == 6'b001000;
`ifdef MC_JUMP_EN
   assign jmp   = opcode == 6'b000010;
   assign jdst  = jmp ? JEX : FETCH;
`else
   assign jmp   = 1'b0;
   assign jdst  = FETCH;
`endif
   assign legal = lw | sw | rtype | beq | addi | jmp;

   // State register; reset parks in IDLE so every decoded output is 0 at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next;
   end

   // Next-state decode; memory states hold until mem_ready completes the access
   always_comb begin
      next = IDLE;
      case (state)
         IDLE:    next = FETCH;
         FETCH:   next = mem_ready ? DECODE : FETCH;
         DECODE:  next = (lw | sw) ? MEMADR : rtype ? RTYPEEX : beq ? BEQEX :
                         addi ? ADDIEX : jdst;
         MEMADR:  next = sw ? MEMWR : MEMRD;
         MEMRD:   next = mem_ready ? MEMWB : MEMRD;
         MEMWR:   next = mem_ready ? FETCH : MEMWR;
         RTYPEEX: next = RTYPEWB;
         ADDIEX:  next = ADDIWB;
         MEMWB, RTYPEWB, BEQEX, ADDIWB: next = FETCH;
`ifdef MC_JUMP_EN
         JEX:     next = FETCH;
`endif
         default: next = IDLE;
      endcase
   end

   assign mem_req  = state == FETCH || state == MEMRD || state == MEMWR;
   assign iord     = state == MEMRD || state == MEMWR;
   assign memwrite = state == MEMWR;
   assign irwrite  = state == FETCH && mem_ready;
   assign branch   = state == BEQEX;
   assign regwrite = state == MEMWB || state == RTYPEWB || state == ADDIWB;
   assign regdst   = state == RTYPEWB;
   assign memtoreg = state == MEMWB;
   assign alusrca  = state == MEMADR || state == RTYPEEX || state == BEQEX || state == ADDIEX;
   assign alusrcb  = state == FETCH ? 2'b01 : state == DECODE ? 2'b11 :
                     (state == MEMADR || state == ADDIEX) ? 2'b10 : 2'b00;
   assign aluop    = state == RTYPEEX ? 2'b10 : state == BEQEX ? 2'b01 : 2'b00;
   assign illegal  = state == DECODE && !legal;
`ifdef MC_JUMP_EN
   assign pcwrite  = (state == FETCH && mem_ready) || state == JEX;
   assign pcsrc    = state == BEQEX ? 2'b01 : state == JEX ? 2'b10 : 2'b00;
`else
   assign pcwrite  = state == FETCH && mem_ready;
   assign pcsrc    = state == BEQEX ? 2'b01 : 2'b00;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control (both MC_JUMP_EN builds)
module tb_mc_control;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite;
   logic       regdst, memtoreg, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;
   logic [20:0] q[$];
   int pass = 0;
   int total = 0;

   mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .pcwrite(pcwrite), .branch(branch), .regwrite(regwrite), .regdst(regdst),
      .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] actual();
      return {state, mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite,
              regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal};
   endfunction

   // expected output table straight from the per-state output list
   function automatic logic [16:0] exp_out(input logic [3:0] s, input logic rdy, input logic ill);
      logic mr, io, mw, irw, pcw, br, rw, rd, m2r, asa, il;
      logic [1:0] asb, pcs, aop;
      {mr, io, mw, irw, pcw, br, rw, rd, m2r, asa, il} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 2'b00;
      case (s)
         4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         4'd1:  begin asb = 2'b11; il = ill; end
         4'd2:  begin asa = 1; asb = 2'b10; end
         4'd3:  begin mr = 1; io = 1; end
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin mr = 1; io = 1; mw = 1; end
         4'd6:  begin asa = 1; aop = 2'b10; end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
         4'd9:  begin asa = 1; asb = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin pcs = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {mr, io, mw, irw, pcw, br, rw, rd, m2r, asa, asb, pcs, aop, il};
   endfunction

   // one cycle: drive inputs, push expectation, compare at negedge, advance
   task automatic step(input string name, input logic [5:0] op, input logic rdy,
                       input logic [3:0] s, input logic ill);
      logic [20:0] e;
      logic [20:0] a;
      opcode = op;
      mem_ready = rdy;
      q.push_back({s, exp_out(s, rdy, ill)});
      @(negedge clk);
      e = q.pop_front();
      a = actual();
      total++;
      if (a !== e) $display("FAIL %s: got %h want %h", name, a, e);
      else pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [20:0] a;
      a = actual();
      total++;
      if (a !== {4'hF, 17'h0}) $display("FAIL reset_hold: got %h want %h", a, {4'hF, 17'h0});
      else pass++;
      step("reset_low", 6'd0, 1'b1, 4'd15, 1'b0);
      rst_n = 1'b1;
      step("reset_idle", 6'd0, 1'b1, 4'd15, 1'b0);
   endtask

   task automatic test_lw();
      logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      foreach (seq[i]) step("lw", 6'b100011, 1'b1, seq[i], 1'b0);
   endtask

   task automatic test_sw_stall();
      step("sw_fetch", 6'b101011, 1'b1, 4'd0, 1'b0);
      step("sw_dec", 6'b101011, 1'b0, 4'd1, 1'b0);
      step("sw_adr", 6'b101011, 1'b1, 4'd2, 1'b0);
      step("sw_wr0", 6'b101011, 1'b0, 4'd5, 1'b0);
      step("sw_wr1", 6'b101011, 1'b0, 4'd5, 1'b0);
      step("sw_wr2", 6'b101011, 1'b1, 4'd5, 1'b0);
   endtask

   task automatic test_rtype_beq();
      step("r_fetch", 6'b000000, 1'b1, 4'd0, 1'b0);
      step("r_dec", 6'b000000, 1'b1, 4'd1, 1'b0);
      step("r_ex", 6'b000000, 1'b1, 4'd6, 1'b0);
      step("r_wb", 6'b000000, 1'b1, 4'd7, 1'b0);
      step("beq_fetch", 6'b000100, 1'b1, 4'd0, 1'b0);
      step("beq_dec", 6'b000100, 1'b1, 4'd1, 1'b0);
      step("beq_ex", 6'b000100, 1'b1, 4'd8, 1'b0);
   endtask

   task automatic test_fetch_stall();
      for (int i = 0; i < 3; i++) step("fetch_wait", 6'b001000, 1'b0, 4'd0, 1'b0);
      step("fetch_rdy", 6'b001000, 1'b1, 4'd0, 1'b0);
      step("addi_dec", 6'b001000, 1'b1, 4'd1, 1'b0);
      step("addi_ex", 6'b001000, 1'b1, 4'd9, 1'b0);
      step("addi_wb", 6'b001000, 1'b1, 4'd10, 1'b0);
   endtask

   task automatic test_jump();
      step("j_fetch", 6'b000010, 1'b1, 4'd0, 1'b0);
`ifdef MC_JUMP_EN
      step("j_dec", 6'b000010, 1'b1, 4'd1, 1'b0);
      step("j_ex", 6'b000010, 1'b1, 4'd11, 1'b0);
`else
      step("j_illegal", 6'b000010, 1'b1, 4'd1, 1'b1);
`endif
   endtask

   task automatic test_illegal();
      step("ill_fetch", 6'b111111, 1'b1, 4'd0, 1'b0);
      step("ill_dec", 6'b111111, 1'b1, 4'd1, 1'b1);
      step("ill_next", 6'b111111, 1'b1, 4'd0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [20:0] a;
      step("rm_dec", 6'b100011, 1'b1, 4'd1, 1'b0);
      step("rm_adr", 6'b100011, 1'b1, 4'd2, 1'b0);
      step("rm_rd", 6'b100011, 1'b0, 4'd3, 1'b0);
      total++;
      if (mem_req !== 1'b1 || state !== 4'd3)
         $display("FAIL rm_req: got %b/%0d want 1/3", mem_req, state);
      else pass++;
      #1 rst_n = 1'b0;
      #1 a = actual();
      total++;
      if (a !== {4'hF, 17'h0}) $display("FAIL rm_async: got %h want %h", a, {4'hF, 17'h0});
      else pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("rm_idle", 6'b100011, 1'b1, 4'd15, 1'b0);
      step("rm_fetch", 6'b100011, 1'b1, 4'd0, 1'b0);
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_lw();
      test_sw_stall();
      test_rtype_beq();
      test_fetch_stall();
      test_jump();
      test_illegal();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
